// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ valid/ready requesters onto one APB slave.
// Optional ACCESS-phase timeout is enabled by defining APB_RR_TIMEOUT_EN.
module apb_rr_master #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [ADDR_WIDTH-1:0]          paddr,
    output logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH-1:0]          prdata,
    input  logic                           pready,
    input  logic                           pslverr
);

    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("apb_rr_master: illegal parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                  r_state, w_state_nxt;
    logic [GW-1:0]           r_gnt, w_gnt_nxt;
    logic [GW-1:0]           r_last_gnt, w_last_gnt_nxt;
    logic                    r_psel, w_psel_nxt;
    logic                    r_penable, w_penable_nxt;
    logic                    r_pwrite, w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr_nxt;
    logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata_nxt;
    logic [NUM_REQ-1:0]      r_req_ready, w_req_ready_nxt;
    logic [NUM_REQ-1:0]      r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic                    r_rsp_err, w_rsp_err_nxt;

    logic [GW-1:0]           w_pick;
    logic                    w_found;
    int                      w_idx;

`ifdef APB_RR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           r_tcnt, w_tcnt_nxt;
`endif

    // First requesting index after the last grant, wrapping around.
    always_comb begin
        w_pick  = r_last_gnt;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last_gnt) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_pick  = GW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_last_gnt_nxt  = r_last_gnt;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
`ifdef APB_RR_TIMEOUT_EN
        w_tcnt_nxt      = r_tcnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt             = S_SETUP;
                    w_gnt_nxt               = w_pick;
                    w_psel_nxt              = 1'b1;
                    w_penable_nxt           = 1'b0;
                    w_pwrite_nxt            = req_write[w_pick];
                    w_paddr_nxt             = req_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    w_pwdata_nxt            = req_wdata[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
                    w_req_ready_nxt[w_pick] = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
`ifdef APB_RR_TIMEOUT_EN
                w_tcnt_nxt    = '0;
`endif
            end
            S_ACCESS: begin
                if (pready) begin
                    w_state_nxt            = S_IDLE;
                    w_psel_nxt             = 1'b0;
                    w_penable_nxt          = 1'b0;
                    w_rsp_valid_nxt[r_gnt] = 1'b1;
                    w_rsp_rdata_nxt        = r_pwrite ? '0 : prdata;
                    w_rsp_err_nxt          = pslverr;
                    w_last_gnt_nxt         = r_gnt;
                end
`ifdef APB_RR_TIMEOUT_EN
                // Slave never answered: complete the request ourselves with an error.
                else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_nxt            = S_IDLE;
                    w_psel_nxt             = 1'b0;
                    w_penable_nxt          = 1'b0;
                    w_rsp_valid_nxt[r_gnt] = 1'b1;
                    w_rsp_rdata_nxt        = '0;
                    w_rsp_err_nxt          = 1'b1;
                    w_last_gnt_nxt         = r_gnt;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_last_gnt  <= GW'(NUM_REQ - 1);
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef APB_RR_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_last_gnt  <= w_last_gnt_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`ifdef APB_RR_TIMEOUT_EN
            r_tcnt      <= w_tcnt_nxt;
`endif
        end
    end

    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: APB slave model with wait states, error address 31 and a stuck mode;
// accepted commands feed a scoreboard that is checked against each response.
module tb_apb_rr_master;
    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              pclk = 1'b0;
    logic              preset = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err, psel, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata, prdata;
    logic              pready, pslverr;

    apb_rr_master #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave model: pready is high outside ACCESS on purpose, the master must ignore it there.
    logic [DW-1:0] slave_mem [32];
    int            tb_wait = 0;
    logic          tb_stuck = 1'b0;
    int            wcnt = 0;

    assign pready  = (psel && penable) ? (!tb_stuck && wcnt >= tb_wait) : 1'b1;
    assign prdata  = (paddr == 5'd31) ? 32'hDEADBEEF : slave_mem[paddr];
    assign pslverr = (paddr == 5'd31);

    always @(posedge pclk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (psel && penable && pready && pwrite && paddr != 5'd31) slave_mem[paddr] <= pwdata;
    end

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t          sb[$];
    int            grants[$];
    logic [31:0]   model [32];
    int            total = 0;
    int            bad = 0;
    int            rsp_cnt = 0;
    int            acc_cnt = 0;
    int            last_acc = 0;
    logic [31:0]   last_rdata = '0;
    logic          last_err = 1'b0;
    logic [AW-1:0] cur_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples just after each active edge.
    always @(posedge pclk) begin
        #1;
        if (!preset) begin
            if (|req_ready) begin
                int          gi;
                logic        w;
                logic [4:0]  a;
                logic [31:0] d;
                exp_t        e;
                gi = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) gi = i;
                w = req_write[gi];
                a = req_addr[gi*AW +: AW];
                d = req_wdata[gi*DW +: DW];
                chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                chk("setup_phase", {62'd0, psel, penable}, 64'd2);
                chk("setup_paddr", 64'(paddr), 64'(a));
                chk("setup_pwrite", 64'(pwrite), 64'(w));
                if (w) chk("setup_pwdata", 64'(pwdata), 64'(d));
                e.idx = gi;
                if (tb_stuck) begin
                    e.rdata = '0; e.err = 1'b1;
                end else if (w) begin
                    e.rdata = '0; e.err = (a == 5'd31);
                    if (a != 5'd31) model[a] = d;
                end else begin
                    e.rdata = (a == 5'd31) ? 32'hDEADBEEF : model[a];
                    e.err   = (a == 5'd31);
                end
                sb.push_back(e);
                grants.push_back(gi);
                acc_cnt  = 0;
                cur_addr = a;
            end
            if (penable) begin
                acc_cnt++;
                chk("access_paddr_stable", 64'(paddr), 64'(cur_addr));
                chk("access_psel", 64'(psel), 64'd1);
            end
            if (|rsp_valid) begin
                int ri;
                ri = 0;
                for (int i = 0; i < NR; i++) if (rsp_valid[i]) ri = i;
                chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
                chk("rsp_psel_low", {62'd0, psel, penable}, 64'd0);
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_idx", 64'(ri), 64'(e.idx));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
                last_acc   = acc_cnt;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                rsp_cnt++;
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [4:0] a, input logic [31:0] d);
        logic seen;
        @(negedge pclk);
        req_valid[i]         = 1'b1;
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge pclk);
            if (req_ready[i]) seen = 1'b1;
        end
        req_valid[i] = 1'b0;
        chk("accept_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int c;
        c = 0;
        while (rsp_cnt < target && c < budget) begin
            @(negedge pclk);
            c++;
        end
        chk("rsp_wait_timeout", 64'(rsp_cnt >= target), 64'd1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        @(posedge pclk); #1;
        chk("rst_apb_ctl", {61'd0, psel, penable, pwrite}, 64'd0);
        chk("rst_paddr_pwdata", {27'd0, paddr, pwdata}, 64'd0);
        chk("rst_handshake", {60'd0, req_ready, rsp_valid}, 64'd0);
        chk("rst_rsp", {31'd0, rsp_err, rsp_rdata}, 64'd0);

        // Write then read back on requester 0, zero-wait slave.
        n = rsp_cnt;
        issue(0, 1'b1, 5'd5, 32'hA5A5_0001);
        wait_rsp(n + 1, 20);
        chk("wr_acc_cycles", 64'(last_acc), 64'd1);
        issue(0, 1'b0, 5'd5, 32'h0);
        wait_rsp(n + 2, 20);
        chk("rd_back_data", 64'(last_rdata), 64'hA5A5_0001);
        chk("rd_back_err", 64'(last_err), 64'd0);

        // Three wait states: four ACCESS cycles, one response.
        tb_wait = 3;
        n = rsp_cnt;
        issue(1, 1'b1, 5'd7, 32'h1234_5678);
        wait_rsp(n + 1, 30);
        chk("wait_acc_cycles", 64'(last_acc), 64'd4);
        issue(1, 1'b0, 5'd7, 32'h0);
        wait_rsp(n + 2, 30);
        chk("wait_rd_data", 64'(last_rdata), 64'h1234_5678);
        tb_wait = 0;
        repeat (3) @(negedge pclk);
        chk("wait_single_rsp", 64'(rsp_cnt), 64'(n + 2));

        // Slave error on address 31.
        n = rsp_cnt;
        issue(0, 1'b0, 5'd31, 32'h0);
        wait_rsp(n + 1, 20);
        chk("err_flag", 64'(last_err), 64'd1);
        chk("err_data", 64'(last_rdata), 64'hDEADBEEF);

        // Stuck slave.
        tb_stuck = 1'b1;
        n = rsp_cnt;
        issue(0, 1'b0, 5'd3, 32'h0);
`ifdef APB_RR_TIMEOUT_EN
        wait_rsp(n + 1, 60);
        chk("tmo_acc_cycles", 64'(last_acc), 64'd16);
        chk("tmo_err", 64'(last_err), 64'd1);
        chk("tmo_rdata", 64'(last_rdata), 64'd0);
        issue(1, 1'b0, 5'd4, 32'h0);
        repeat (5) @(negedge pclk);
`else
        repeat (100) @(negedge pclk);
        chk("stuck_no_rsp", 64'(rsp_cnt), 64'(n));
`endif
        // Reset while in ACCESS: bus drops, no response, pointer back to NUM_REQ-1.
        chk("pre_reset_in_access", 64'(penable), 64'd1);
        n = rsp_cnt;
        preset = 1'b1;
        @(posedge pclk); #1;
        chk("reset_abort_bus", {62'd0, psel, penable}, 64'd0);
        chk("reset_abort_rsp", 64'(rsp_valid), 64'd0);
        @(negedge pclk);
        preset   = 1'b0;
        tb_stuck = 1'b0;
        sb.delete();
        repeat (2) @(negedge pclk);
        chk("reset_no_late_rsp", 64'(rsp_cnt), 64'(n));

        // Both requesters held: strict alternation starting with requester 0.
        grants.delete();
        n = rsp_cnt;
        @(negedge pclk);
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {5'd11, 5'd10};
        req_wdata = {32'h0000_B111, 32'h0000_A010};
        for (int c = 0; c < 200 && grants.size() < 4; c++) @(negedge pclk);
        req_valid = 2'b00;
        wait_rsp(n + 4, 40);
        chk("rr_grant_count", 64'(grants.size()), 64'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            chk("rr_order", 64'(grants[k]), 64'(k % 2));
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);

        // Idle bus stays quiet.
        repeat (5) @(negedge pclk);
        chk("idle_psel", 64'(psel), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
